// File: rtl/vector_vcr_writeback.sv
// VCR write-back stage: aligns compare type with result, packs lane codes,
// buffers them in a small FIFO and drains into the condition register.
package valu_pkg;
  typedef enum logic [1:0] {
    FULL  = 2'd0,
    HALF  = 2'd1,
    UNDEF = 2'd2
  } elem_type_e;
endpackage

module vector_vcr_writeback
  import valu_pkg::*;
#(
  parameter int NUM_ELEMS = 8,
  parameter int ELEM_SIZE = 16,
  parameter int DEPTH     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   issue,
  input  elem_type_e             elem_type,
  input  logic                   result_avail,
  input  logic                   write_vcr,
  input  logic [2*NUM_ELEMS-1:0] cmp_lt,
  input  logic [2*NUM_ELEMS-1:0] cmp_gt,
  input  logic                   wb_stall,
  output logic                   ready,
  output logic                   vcr_pending,
  output logic [4*NUM_ELEMS-1:0] vcr,
  output logic                   vcr_we,
  output logic                   err
);

  localparam int LANES = 2 * NUM_ELEMS;
  localparam int GRP   = (ELEM_SIZE / 8 < 1) ? 1 : ELEM_SIZE / 8;
  localparam int VW    = 2 * LANES;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 2) + 1;

  elem_type_e      type_q, type_d;
  logic [VW-1:0]   mem_q [DEPTH];
  logic [VW-1:0]   mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   vcr_q, vcr_d;
  logic            vcr_we_q, vcr_we_d;
  logic            err_q, err_d;

  logic [VW-1:0]   code;
  logic            cerr;
  logic            pop;
  logic            push;
  logic            ret_nw;
  logic            inc;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    code = '0;
    cerr = 1'b0;
    unique case (type_q)
      HALF: begin
        for (int j = 0; j < LANES; j++) begin
          code[2*j +: 2] = {cmp_lt[j], cmp_gt[j]};
          cerr = cerr | (cmp_lt[j] & cmp_gt[j]);
        end
      end
      FULL: begin
        for (int j = 0; j < LANES; j++) begin
          code[2*j +: 2] = {cmp_lt[j - (j % GRP)], cmp_gt[j - (j % GRP)]};
          if (j % GRP == 0)
            cerr = cerr | (cmp_lt[j] & cmp_gt[j]);
        end
      end
      default: begin
        code = '1;
        cerr = 1'b1;
      end
    endcase
  end

  // A pop this cycle frees a slot, so back-to-back issue can sustain.
  assign pop         = !empty_q && !wb_stall;
  assign push        = result_avail && write_vcr && (!full_q || pop);
  assign ret_nw      = result_avail && !write_vcr;
  assign ready       = cnt_q < (CW'(DEPTH) + CW'(pop));
  assign inc         = issue && ready;
  assign vcr_pending = cnt_q != '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    if (push) begin
      mem_d[wr_ptr_q] = code;
      wr_ptr_d        = nxt_ptr(wr_ptr_q);
    end
    if (pop)
      rd_ptr_d = nxt_ptr(rd_ptr_q);
    if (push && !pop) begin
      empty_d = 1'b0;
      full_d  = nxt_ptr(wr_ptr_q) == rd_ptr_q;
    end else if (pop && !push) begin
      full_d  = 1'b0;
      empty_d = nxt_ptr(rd_ptr_q) == wr_ptr_q;
    end
  end

  always_comb begin
    type_d   = inc ? elem_type : type_q;
    cnt_d    = cnt_q + CW'(inc) - CW'(pop) - CW'(ret_nw);
    vcr_d    = pop ? mem_q[rd_ptr_q] : vcr_q;
    vcr_we_d = pop;
    err_d    = err_q | (result_avail & cerr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      type_q   <= FULL;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      cnt_q    <= '0;
      vcr_q    <= '0;
      vcr_we_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      type_q   <= type_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      cnt_q    <= cnt_d;
      vcr_q    <= vcr_d;
      vcr_we_q <= vcr_we_d;
      err_q    <= err_d;
    end
  end

  assign vcr    = vcr_q;
  assign vcr_we = vcr_we_q;
  assign err    = err_q;

endmodule

// File: tb/tb_vector_vcr_writeback.sv
// Directed bench for vector_vcr_writeback: vector table plus
// stall, streaming, retire-without-write and async reset sequences.
module tb_vector_vcr_writeback;
  import valu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue;
  elem_type_e  elem_type;
  logic        result_avail;
  logic        write_vcr;
  logic [15:0] cmp_lt;
  logic [15:0] cmp_gt;
  logic        wb_stall;
  logic        ready;
  logic        vcr_pending;
  logic [31:0] vcr;
  logic        vcr_we;
  logic        err;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vector_vcr_writeback #(
    .NUM_ELEMS(8),
    .ELEM_SIZE(16),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .issue(issue),
    .elem_type(elem_type),
    .result_avail(result_avail),
    .write_vcr(write_vcr),
    .cmp_lt(cmp_lt),
    .cmp_gt(cmp_gt),
    .wb_stall(wb_stall),
    .ready(ready),
    .vcr_pending(vcr_pending),
    .vcr(vcr),
    .vcr_we(vcr_we),
    .err(err)
  );

  typedef struct {
    elem_type_e  t;
    logic [15:0] lt;
    logic [15:0] gt;
    logic [31:0] exp_vcr;
    logic        exp_err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue        = 1'b0;
    elem_type    = HALF;
    result_avail = 1'b0;
    write_vcr    = 1'b0;
    cmp_lt       = '0;
    cmp_gt       = '0;
  endtask

  task automatic do_reset();
    idle();
    wb_stall = 1'b0;
    reset_n  = 1'b0;
    tick();
    tick();
    reset_n  = 1'b1;
  endtask

  function automatic logic [31:0] half_lt(input logic [15:0] lt);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      r[2*j+1] = lt[j];
    return r;
  endfunction

  task automatic xact(input string nm, input elem_type_e t,
                      input logic [15:0] lt, input logic [15:0] gt,
                      input logic [31:0] ev, input logic ee);
    issue     = 1'b1;
    elem_type = t;
    chk({nm, ".ready"}, 32'(ready), 32'd1);
    tick();
    chk({nm, ".pend0"}, 32'(vcr_pending), 32'd1);
    issue        = 1'b0;
    elem_type    = HALF;
    result_avail = 1'b1;
    write_vcr    = 1'b1;
    cmp_lt       = lt;
    cmp_gt       = gt;
    tick();
    chk({nm, ".we_early"}, 32'(vcr_we), 32'd0);
    chk({nm, ".pend1"}, 32'(vcr_pending), 32'd1);
    idle();
    tick();
    chk({nm, ".we"}, 32'(vcr_we), 32'd1);
    chk({nm, ".vcr"}, vcr, ev);
    chk({nm, ".err"}, 32'(err), 32'(ee));
    chk({nm, ".pend2"}, 32'(vcr_pending), 32'd0);
    tick();
    chk({nm, ".we_off"}, 32'(vcr_we), 32'd0);
  endtask

  logic [15:0] pats [5];

  initial begin
    tbl[0] = '{HALF,  16'h000F, 16'h00F0, 32'h0000_55AA, 1'b0};
    tbl[1] = '{FULL,  16'h0001, 16'h0004, 32'h0000_005A, 1'b0};
    tbl[2] = '{HALF,  16'hFFFF, 16'h0000, 32'hAAAA_AAAA, 1'b0};
    tbl[3] = '{HALF,  16'h0000, 16'hFFFF, 32'h5555_5555, 1'b0};
    tbl[4] = '{FULL,  16'h0100, 16'h0042, 32'h000A_5000, 1'b0};
    tbl[5] = '{FULL,  16'h8000, 16'h0000, 32'h0000_0000, 1'b0};
    tbl[6] = '{HALF,  16'h8000, 16'h4000, 32'h9000_0000, 1'b0};
    tbl[7] = '{UNDEF, 16'h0000, 16'h0000, 32'hFFFF_FFFF, 1'b1};
    tbl[8] = '{HALF,  16'h0001, 16'h0001, 32'h0000_0003, 1'b1};
    pats   = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'hFFFF};

    do_reset();
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.pend", 32'(vcr_pending), 32'd0);
    chk("rst.vcr", vcr, 32'd0);
    chk("rst.we", 32'(vcr_we), 32'd0);
    chk("rst.err", 32'(err), 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      xact($sformatf("vec%0d", i), tbl[i].t, tbl[i].lt, tbl[i].gt,
           tbl[i].exp_vcr, tbl[i].exp_err);
    end

    // err stays set across a clean transaction, clears on reset
    do_reset();
    xact("sticky_a", UNDEF, 16'h0000, 16'h0000, 32'hFFFF_FFFF, 1'b1);
    xact("sticky_b", HALF, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1);
    do_reset();
    chk("sticky.clr", 32'(err), 32'd0);

    // stalled port: FIFO fills, third issue ignored, drain in order
    do_reset();
    wb_stall  = 1'b1;
    issue     = 1'b1;
    elem_type = HALF;
    chk("st.ready0", 32'(ready), 32'd1);
    tick();
    result_avail = 1'b1;
    write_vcr    = 1'b1;
    cmp_lt       = 16'h0001;
    chk("st.ready1", 32'(ready), 32'd1);
    tick();
    chk("st.ready2", 32'(ready), 32'd0);
    cmp_lt = 16'h0002;
    tick();
    chk("st.ready3", 32'(ready), 32'd0);
    chk("st.pend", 32'(vcr_pending), 32'd1);
    chk("st.we0", 32'(vcr_we), 32'd0);
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st.hold_we", 32'(vcr_we), 32'd0);
      chk("st.hold_rdy", 32'(ready), 32'd0);
    end
    wb_stall = 1'b0;
    tick();
    chk("st.we_a", 32'(vcr_we), 32'd1);
    chk("st.vcr_a", vcr, 32'h0000_0002);
    tick();
    chk("st.we_b", 32'(vcr_we), 32'd1);
    chk("st.vcr_b", vcr, 32'h0000_0008);
    tick();
    chk("st.we_c", 32'(vcr_we), 32'd0);
    chk("st.pend_c", 32'(vcr_pending), 32'd0);
    chk("st.ready_c", 32'(ready), 32'd1);
    chk("st.vcr_c", vcr, 32'h0000_0008);

    // result not targeting VCR still retires the issue
    issue = 1'b1;
    tick();
    issue        = 1'b0;
    result_avail = 1'b1;
    write_vcr    = 1'b0;
    cmp_lt       = 16'hFFFF;
    tick();
    chk("nw.pend", 32'(vcr_pending), 32'd0);
    idle();
    tick();
    chk("nw.we", 32'(vcr_we), 32'd0);
    chk("nw.vcr", vcr, 32'h0000_0008);

    // issue every cycle: one write per cycle, order kept
    for (int k = 0; k < 7; k++) begin
      issue        = (k < 5);
      elem_type    = HALF;
      result_avail = (k >= 1 && k <= 5);
      write_vcr    = 1'b1;
      cmp_lt       = (k >= 1 && k <= 5) ? pats[k-1] : 16'h0;
      cmp_gt       = '0;
      if (k < 5)
        chk($sformatf("strm.ready%0d", k), 32'(ready), 32'd1);
      tick();
      if (k >= 2) begin
        chk($sformatf("strm.we%0d", k), 32'(vcr_we), 32'd1);
        chk($sformatf("strm.vcr%0d", k), vcr, half_lt(pats[k-2]));
      end
    end
    idle();
    tick();
    chk("strm.end_we", 32'(vcr_we), 32'd0);
    chk("strm.end_pend", 32'(vcr_pending), 32'd0);

    // async reset with the FIFO full under stall
    wb_stall  = 1'b1;
    issue     = 1'b1;
    elem_type = HALF;
    tick();
    result_avail = 1'b1;
    write_vcr    = 1'b1;
    cmp_lt       = 16'h0001;
    cmp_gt       = 16'h0001;
    tick();
    issue  = 1'b0;
    cmp_lt = 16'h0004;
    cmp_gt = 16'h0000;
    tick();
    chk("ar.err_pre", 32'(err), 32'd1);
    chk("ar.rdy_pre", 32'(ready), 32'd0);
    chk("ar.vcr_pre", vcr, 32'hAAAA_AAAA);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar.ready", 32'(ready), 32'd1);
    chk("ar.pend", 32'(vcr_pending), 32'd0);
    chk("ar.vcr", vcr, 32'd0);
    chk("ar.we", 32'(vcr_we), 32'd0);
    chk("ar.err", 32'(err), 32'd0);
    #2;
    reset_n  = 1'b1;
    wb_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ar.post_we", 32'(vcr_we), 32'd0);
      chk("ar.post_vcr", vcr, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
